// File: rtl/axi_rd_fifo_unpack.sv
// Read-data buffer behind the AXI read master: stores 64-bit beats and
// streams them out as 32-bit words (low half first) on a valid/ready port.
module axi_rd_fifo_unpack #(
  parameter int DEPTH       = 512,
  parameter int AFULL_SPACE = 256
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   FLUSH,
  input  logic                   RD_FIFO_WE,
  input  logic [63:0]            RD_FIFO_DATA,
  output logic                   RD_FIFO_FULL,
  output logic                   RD_FIFO_AFULL,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [31:0]            OUT_DATA,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   OVERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_LEVEL = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_THR  = PW'(DEPTH - AFULL_SPACE);

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] level;
  logic [63:0]   hold;
  logic          hold_valid;
  logic          sel;
  logic          overflow;
  logic          full;
  logic          wr_en;
  logic          out_hs;
  logic          pop;

  // Pointers carry an extra wrap bit, so plain subtraction gives the fill level.
  assign level  = wr_ptr - rd_ptr;
  assign full   = (level == FULL_LEVEL);
  assign wr_en  = RD_FIFO_WE & ~full;
  assign out_hs = hold_valid & OUT_READY;
  // Pop only on the pre-write level, so a beat never bypasses the array.
  assign pop    = (level != '0) & (~hold_valid | (out_hs & sel));

  // NOTE: the storage array has no reset; contents are only observable after
  // a write, and a reset term would block mapping it onto block RAM.
  always_ff @(posedge ACLK) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= RD_FIFO_DATA;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      sel        <= 1'b0;
      overflow   <= 1'b0;
    end else if (FLUSH) begin
      rd_ptr     <= wr_ptr;
      hold_valid <= 1'b0;
      sel        <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (RD_FIFO_WE && full) overflow <= 1'b1;
      if (pop) begin
        hold       <= mem[rd_ptr[AW-1:0]];
        rd_ptr     <= rd_ptr + 1'b1;
        hold_valid <= 1'b1;
        sel        <= 1'b0;
      end else if (out_hs) begin
        if (!sel) begin
          sel <= 1'b1;
        end else begin
          hold_valid <= 1'b0;
          sel        <= 1'b0;
        end
      end
    end
  end

  assign RD_FIFO_FULL  = full;
  assign RD_FIFO_AFULL = (level > AFULL_THR);
  assign LEVEL         = level;
  assign OVERFLOW      = overflow;
  assign OUT_VALID     = hold_valid;
  assign OUT_DATA      = sel ? hold[63:32] : hold[31:0];

endmodule
